// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, baud divider helper and the
// command characters understood by the debug controller.
package uart_pkg;

    // Receiver FSM state encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StData  = 2'b10,
        StStop  = 2'b11
    } uart_state_t;

    // Command characters sent by the host PC to the debug controller.
    localparam logic [7:0] CharC = 8'h63;  // 'c'
    localparam logic [7:0] CharS = 8'h73;  // 's'
    localparam logic [7:0] CharD = 8'h64;  // 'd'
    localparam logic [7:0] CharN = 8'h6E;  // 'n'

    // Clocks per oversample tick, truncated, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        int unsigned div;
        div = clk_freq / (baud_rate * oversample);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle pulse every DIV clocks. The restart input
// zeroes the divider so ticks line up with a detected start edge.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Free-running divider, zeroed on restart
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 framing with OVERSAMPLE ticks per bit.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority of the
// samples around mid-bit instead of a single mid-bit sample.
// The sample counter runs bit-relative (0 at the bit's leading edge), so every
// bit decision lands on the same count value.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_rx_reset,
    output logic                 o_rx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_frame_error
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SCW-1:0] S_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] S_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic [SCW-1:0]       r_sample_cnt;
    logic [BCW-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_ready;
    logic                 r_frame_err;
    logic                 r_rx_meta;
    logic                 r_rx_s;

    logic w_tick;
    logic w_restart;
    logic w_start_check;
    logic w_start_high;
    logic w_start_go;
    logic w_bit_now;
    logic w_bit_val;

    // Two-flop synchroniser for the asynchronous serial line, idles high
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Realign the divider to the start edge as the FSM leaves IDLE
    assign w_restart = (r_state == StIdle) && !r_rx_s;

    baud_tick_gen #(
        .DIV(DIV)
    ) u_baud_tick_gen (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [SCW-1:0] S_PRE  = SCW'(OVERSAMPLE / 2 - 2);
    localparam logic [SCW-1:0] S_POST = SCW'(OVERSAMPLE / 2);

    // r_maj[1] holds the sample at S_PRE, r_maj[0] the one at S_MID
    logic [1:0] r_maj;

    // Capture the two samples preceding each majority decision
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_maj <= 2'b11;
        end else if (w_tick && ((r_sample_cnt == S_PRE) || (r_sample_cnt == S_MID))) begin
            r_maj <= {r_maj[0], r_rx_s};
        end
    end

    // Start check has only two samples so far: both must be low
    assign w_start_check = w_tick && (r_sample_cnt == S_MID);
    assign w_start_high  = r_maj[0] | r_rx_s;
    // Enter DATA one tick later so the first data decision is a full bit away
    assign w_start_go    = w_tick && (r_sample_cnt == S_POST);
    assign w_bit_now     = w_tick && (r_sample_cnt == S_POST);
    assign w_bit_val     = (r_maj[1] & r_maj[0]) | (r_maj[1] & r_rx_s) | (r_maj[0] & r_rx_s);
`else
    assign w_start_check = w_tick && (r_sample_cnt == S_MID);
    assign w_start_high  = r_rx_s;
    assign w_start_go    = w_start_check;
    assign w_bit_now     = w_start_check;
    assign w_bit_val     = r_rx_s;
`endif

    // Frame FSM with registered data, ready flag and frame-error pulse
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_ready      <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            // Consumer clear; a set later in this block overrides it
            if (i_rx_reset) begin
                r_ready <= 1'b0;
            end
            if (w_tick && (r_state != StIdle)) begin
                r_sample_cnt <= (r_sample_cnt == S_LAST) ? '0 : r_sample_cnt + 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (!r_rx_s) begin
                        r_state      <= StStart;
                        r_sample_cnt <= '0;
                    end
                end
                StStart: begin
                    if (w_start_check && w_start_high) begin
                        r_state <= StIdle;
                    end else if (w_start_go) begin
                        r_state   <= StData;
                        r_bit_cnt <= '0;
                    end
                end
                StData: begin
                    if (w_bit_now) begin
                        r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == B_LAST) begin
                            r_state <= StStop;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (w_bit_now) begin
                        r_state <= StIdle;
                        if (w_bit_val) begin
                            r_rx_data <= r_shift;
                            r_ready   <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Mask keeps a byte hidden while the consumer's clear is still high
    assign o_rx_ready    = r_ready & ~i_rx_reset;
    assign o_rx_data     = r_rx_data;
    assign o_frame_error = r_frame_err;

endmodule
